serial_run_detector: RTL and testbench
======================================

# serial_run_detector

- Parametrised successor of the single-bit serial detector: watches a serial bit stream and detects runs of consecutive equal bits.
- Per-cycle outputs: a threshold-hit pulse, plus a completed-run report (bit value, saturated length).
- Sits directly behind the serial input of the lab design, one sample per qualified clock edge.
- Adds a sample qualifier, polarity mode, configurable threshold and counter width, flush and saturation, none of which the previous fixed detector had.

## Interface
- CNT_W, 4: width of the run-length counter and of runLen; legal 2..16.
- MIN_RUN, 3: run length that triggers dataOut; legal 1..2^CNT_W-1.
- MODE, 2: 0 = detect runs of ones only, 1 = runs of zeros only, 2 = both polarities.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dataValid  input  1  dataIn is a sample this cycle.
- dataIn  input  1  serial data bit, ignored when dataValid=0.
- flush  input  1  close the current run and report it.
- dataOut  output  1  one-cycle pulse, current run of matching polarity just reached MIN_RUN.
- runDone  output  1  one-cycle pulse, runVal/runLen/runSat are valid.
- runVal  output  1  bit value of the reported run.
- runLen  output  CNT_W  length of the reported run, saturated.
- runSat  output  1  reported run reached 2^CNT_W-1, true length may be larger.

## Operation
- States:
  - IDLE: no run open.
  - RUN: run open; internal curVal and cnt hold the run value and length.
- Reset: all outputs 0, state IDLE, cnt=0, curVal=0. Reset mid-run discards the open run with no report.
- "match(b)" means: b=1 for MODE 0, b=0 for MODE 1, always for MODE 2.
- Sample in IDLE:
  - Set curVal<=b, cnt<=1, go to RUN.
  - If MIN_RUN==1 and match(b), pulse dataOut.
- Sample in RUN, b==curVal:
  - cnt<=cnt+1, saturating at 2^CNT_W-1.
  - Pulse dataOut iff match(b) and the unsaturated cnt+1 == MIN_RUN. Exactly one pulse per run, never re-fires while saturated.
- Sample in RUN, b!=curVal:
  - Pulse runDone with runVal<=curVal, runLen<=cnt, runSat<=(cnt==2^CNT_W-1).
  - Start the new run: curVal<=b, cnt<=1.
  - If MIN_RUN==1 and match(b), dataOut pulses in the same cycle as runDone.
- dataValid=0: state, cnt and curVal hold. Gaps do not break a run.
- flush in RUN:
  - Report the open run exactly as a value change would, then go to IDLE.
  - A sample presented in the same cycle as flush is discarded.
- flush in IDLE: no effect, no runDone.
- runDone reports every run regardless of MODE. MODE gates only dataOut.
- runVal/runLen/runSat hold their last reported values between runDone pulses.

## Timing
- All outputs are registered. They respond on the rising edge that captures the sample, visible for the following cycle.
- Latency:
  - dataOut: 1 cycle after the edge sampling the MIN_RUN-th bit.
  - runDone: 1 cycle after the edge sampling the first differing bit, or the edge capturing flush.
- dataOut and runDone are high for exactly one cycle per event.
- Back-to-back events on consecutive edges produce consecutive pulses.
- Throughput: one sample per clock, no back-pressure.
- Async rst assertion clears outputs immediately. First sample is accepted on the first rising edge with rst low.

## Test plan
- Stimulus pattern: CNT_W=4, MIN_RUN=3, MODE=2; after reset, valid stream 1,0,1,1,0,0,1,1,1,0,0,0,0, then flush. Required responses:
  - runDone reports (runVal,runLen) = (1,1), (0,1), (1,2), (0,2), (1,3), then (0,4) on flush.
  - dataOut pulses twice: after the 9th sample and after the 12th sample.
- Same stream with MODE=0 (then MODE=1):
  - dataOut pulses only after the 9th sample (MODE=0), only after the 12th sample (MODE=1).
  - runDone reports are identical to the MODE=2 case.
- Saturation, CNT_W=3, MIN_RUN=7: twelve 1s then a 0.
  - One dataOut after the 7th sample.
  - runDone with runVal=1, runLen=7, runSat=1.
- Valid gaps: 1,1 then dataValid=0 for 5 cycles then 1,0 (MIN_RUN=3).
  - dataOut after the third 1.
  - runDone (1,3); the gap neither breaks the run nor counts.
- MIN_RUN=1, MODE=2, alternating 1,0,1:
  - dataOut pulses after every sample.
  - runDone coincides with dataOut from the 2nd sample on, reporting length 1.
- Reset mid-run: 1,1 then rst pulse for 2 cycles, then 0,1.
  - All outputs 0 during reset; no report for the discarded run.
  - First runDone reports (0,1).

Source files
------------

// File: rtl/serial_run_detector_if.sv
// Bundle of the serial sample inputs and the run-report outputs of serial_run_detector.
//   master: the stream source, which drives dataValid/dataIn/flush and observes the reports.
//   slave : the detector, which receives the samples and drives dataOut/runDone/runVal/runLen/runSat.
// CNT_W must match the detector's CNT_W; it sets the width of runLen.
interface serial_run_detector_if #(
  parameter int unsigned CNT_W = 4
);
  logic             dataValid;
  logic             dataIn;
  logic             flush;
  logic             dataOut;
  logic             runDone;
  logic             runVal;
  logic [CNT_W-1:0] runLen;
  logic             runSat;

  modport master (
    output dataValid, dataIn, flush,
    input  dataOut, runDone, runVal, runLen, runSat
  );

  modport slave (
    input  dataValid, dataIn, flush,
    output dataOut, runDone, runVal, runLen, runSat
  );
endinterface

// File: rtl/serial_run_detector.sv
// Serial run detector. It watches a qualified serial bit stream and tracks runs of equal bits.
//   clk : rising-edge clock.
//   rst : asynchronous, active-high reset.
//   bus : serial_run_detector_if slave.
//         in : dataValid (sample qualifier), dataIn (sample bit), flush (close the open run).
//         out: dataOut (pulse when a run of the selected polarity reaches MIN_RUN).
//              runDone (pulse when runVal/runLen/runSat report a completed run).
// Parameters:
//   CNT_W   width of the run-length counter (2..16).
//   MIN_RUN run length that fires dataOut.
//   MODE    0 = runs of ones, 1 = runs of zeros, 2 = both polarities. MODE gates only dataOut.
// All outputs are registered.
module serial_run_detector #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned MIN_RUN = 3,
  parameter int unsigned MODE    = 2
) (
  input logic                 clk,
  input logic                 rst,
  serial_run_detector_if.slave bus
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   MinRun = (CNT_W + 1)'(MIN_RUN);

  logic [0:0]       state_q, state_d;
  logic             cur_val_q, cur_val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_out_q, data_out_d;
  logic             run_done_q, run_done_d;
  logic             run_val_q, run_val_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic             run_sat_q, run_sat_d;

  // One bit wider than the counter, so a saturated count can never equal MinRun again.
  logic [CNT_W:0]   cnt_inc;

  function automatic logic polarity_match(input logic b);
    if (MODE == 0) begin
      return b;
    end else if (MODE == 1) begin
      return ~b;
    end
    return 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    cur_val_d  = cur_val_q;
    cnt_d      = cnt_q;
    data_out_d = 1'b0;
    run_done_d = 1'b0;
    run_val_d  = run_val_q;
    run_len_d  = run_len_q;
    run_sat_d  = run_sat_q;
    cnt_inc    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    if (bus.flush) begin
      // Any sample presented together with flush is discarded.
      if (state_q == StRun) begin
        run_done_d = 1'b1;
        run_val_d  = cur_val_q;
        run_len_d  = cnt_q;
        run_sat_d  = (cnt_q == CntMax);
        state_d    = StIdle;
        cnt_d      = '0;
      end
    end else if (bus.dataValid) begin
      if (state_q == StIdle) begin
        state_d    = StRun;
        cur_val_d  = bus.dataIn;
        cnt_d      = CNT_W'(1);
        data_out_d = (MIN_RUN == 1) && polarity_match(bus.dataIn);
      end else if (bus.dataIn == cur_val_q) begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
        data_out_d = polarity_match(bus.dataIn) && (cnt_inc == MinRun);
      end else begin
        run_done_d = 1'b1;
        run_val_d  = cur_val_q;
        run_len_d  = cnt_q;
        run_sat_d  = (cnt_q == CntMax);
        cur_val_d  = bus.dataIn;
        cnt_d      = CNT_W'(1);
        data_out_d = (MIN_RUN == 1) && polarity_match(bus.dataIn);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cur_val_q  <= 1'b0;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      run_done_q <= 1'b0;
      run_val_q  <= 1'b0;
      run_len_q  <= '0;
      run_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_val_q  <= cur_val_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      run_done_q <= run_done_d;
      run_val_q  <= run_val_d;
      run_len_q  <= run_len_d;
      run_sat_q  <= run_sat_d;
    end
  end

  assign bus.dataOut = data_out_q;
  assign bus.runDone = run_done_q;
  assign bus.runVal  = run_val_q;
  assign bus.runLen  = run_len_q;
  assign bus.runSat  = run_sat_q;

endmodule

// File: tb/tb_serial_run_detector.sv
// Self-checking bench for serial_run_detector. Five detector configurations share one
// stimulus stream. Each configuration is compared every cycle against a run-level reference
// model that tracks the true, unbounded length of the open run.
module tb_serial_run_detector;

  localparam int NDut = 5;
  // Configuration table: CNT_W, MIN_RUN, MODE.
  localparam int CfgCw [NDut] = '{4, 4, 4, 3, 4};
  localparam int CfgMr [NDut] = '{3, 3, 3, 7, 1};
  localparam int CfgMd [NDut] = '{2, 0, 1, 2, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv  = 1'b0;
  logic di  = 1'b0;
  logic fl  = 1'b0;

  always #5 clk = ~clk;

  serial_run_detector_if #(.CNT_W(4)) if0 ();
  serial_run_detector_if #(.CNT_W(4)) if1 ();
  serial_run_detector_if #(.CNT_W(4)) if2 ();
  serial_run_detector_if #(.CNT_W(3)) if3 ();
  serial_run_detector_if #(.CNT_W(4)) if4 ();

  assign if0.dataValid = dv;
  assign if0.dataIn    = di;
  assign if0.flush     = fl;
  assign if1.dataValid = dv;
  assign if1.dataIn    = di;
  assign if1.flush     = fl;
  assign if2.dataValid = dv;
  assign if2.dataIn    = di;
  assign if2.flush     = fl;
  assign if3.dataValid = dv;
  assign if3.dataIn    = di;
  assign if3.flush     = fl;
  assign if4.dataValid = dv;
  assign if4.dataIn    = di;
  assign if4.flush     = fl;

  serial_run_detector #(.CNT_W(4), .MIN_RUN(3), .MODE(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  serial_run_detector #(.CNT_W(4), .MIN_RUN(3), .MODE(0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  serial_run_detector #(.CNT_W(4), .MIN_RUN(3), .MODE(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  serial_run_detector #(.CNT_W(3), .MIN_RUN(7), .MODE(2)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
  serial_run_detector #(.CNT_W(4), .MIN_RUN(1), .MODE(2)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic        o_do  [NDut];
  logic        o_rd  [NDut];
  logic        o_rv  [NDut];
  logic [15:0] o_rl  [NDut];
  logic        o_rs  [NDut];

  assign o_do[0] = if0.dataOut;
  assign o_rd[0] = if0.runDone;
  assign o_rv[0] = if0.runVal;
  assign o_rl[0] = 16'(if0.runLen);
  assign o_rs[0] = if0.runSat;
  assign o_do[1] = if1.dataOut;
  assign o_rd[1] = if1.runDone;
  assign o_rv[1] = if1.runVal;
  assign o_rl[1] = 16'(if1.runLen);
  assign o_rs[1] = if1.runSat;
  assign o_do[2] = if2.dataOut;
  assign o_rd[2] = if2.runDone;
  assign o_rv[2] = if2.runVal;
  assign o_rl[2] = 16'(if2.runLen);
  assign o_rs[2] = if2.runSat;
  assign o_do[3] = if3.dataOut;
  assign o_rd[3] = if3.runDone;
  assign o_rv[3] = if3.runVal;
  assign o_rl[3] = 16'(if3.runLen);
  assign o_rs[3] = if3.runSat;
  assign o_do[4] = if4.dataOut;
  assign o_rd[4] = if4.runDone;
  assign o_rv[4] = if4.runVal;
  assign o_rl[4] = 16'(if4.runLen);
  assign o_rs[4] = if4.runSat;

  // Reference model state: whether a run is open, its bit value and its true length.
  bit m_open [NDut];
  bit m_cur  [NDut];
  int m_len  [NDut];
  // Expected registered outputs.
  bit e_do   [NDut];
  bit e_rd   [NDut];
  bit e_rv   [NDut];
  int e_rl   [NDut];
  bit e_rs   [NDut];
  // Pulse counters for the directed scenarios.
  int n_do   [NDut];
  int n_rd   [NDut];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit wants(int i, bit b);
    return (CfgMd[i] == 2) || (CfgMd[i] == 0 && b) || (CfgMd[i] == 1 && !b);
  endfunction

  function automatic void model_report(int i);
    int max_len = (1 << CfgCw[i]) - 1;
    e_rd[i] = 1'b1;
    e_rv[i] = m_cur[i];
    e_rl[i] = (m_len[i] > max_len) ? max_len : m_len[i];
    e_rs[i] = (m_len[i] >= max_len);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NDut; i++) begin
      m_open[i] = 1'b0;
      m_cur[i]  = 1'b0;
      m_len[i]  = 0;
      e_do[i]   = 1'b0;
      e_rd[i]   = 1'b0;
      e_rv[i]   = 1'b0;
      e_rl[i]   = 0;
      e_rs[i]   = 1'b0;
    end
  endfunction

  function automatic void model_step(int i, bit v, bit d, bit f);
    e_do[i] = 1'b0;
    e_rd[i] = 1'b0;
    if (f) begin
      if (m_open[i]) begin
        model_report(i);
        m_open[i] = 1'b0;
      end
    end else if (v) begin
      if (m_open[i] && d == m_cur[i]) begin
        m_len[i]++;
        e_do[i] = wants(i, d) && (m_len[i] == CfgMr[i]);
      end else begin
        if (m_open[i]) model_report(i);
        m_open[i] = 1'b1;
        m_cur[i]  = d;
        m_len[i]  = 1;
        e_do[i]   = wants(i, d) && (CfgMr[i] == 1);
      end
    end
  endfunction

  task automatic compare_all();
    for (int i = 0; i < NDut; i++) begin
      check($sformatf("u%0d.dataOut", i), 32'(o_do[i]), 32'(e_do[i]));
      check($sformatf("u%0d.runDone", i), 32'(o_rd[i]), 32'(e_rd[i]));
      check($sformatf("u%0d.runVal", i),  32'(o_rv[i]), 32'(e_rv[i]));
      check($sformatf("u%0d.runLen", i),  32'(o_rl[i]), 32'(e_rl[i]));
      check($sformatf("u%0d.runSat", i),  32'(o_rs[i]), 32'(e_rs[i]));
    end
  endtask

  task automatic step(input bit v, input bit d, input bit f);
    dv = v;
    di = d;
    fl = f;
    @(posedge clk);
    #1;
    for (int i = 0; i < NDut; i++) begin
      model_step(i, v, d, f);
      if (o_do[i] === 1'b1) n_do[i]++;
      if (o_rd[i] === 1'b1) n_rd[i]++;
    end
    compare_all();
  endtask

  // Asserts reset away from the clock edge, checks outputs clear at once and stay clear.
  task automatic do_reset(input int cycles);
    dv  = 1'b0;
    fl  = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NDut; i++) begin
      n_do[i] = 0;
      n_rd[i] = 0;
    end
  endtask

  initial begin
    bit stream_a [13] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0};
    bit cur = 1'b0;

    do_reset(2);

    // Mixed stream, then flush. MODE 2 / 0 / 1 differ only in dataOut.
    clear_counts();
    foreach (stream_a[k]) step(1'b1, stream_a[k], 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("a.u0.dataOut_pulses", 32'(n_do[0]), 32'd2);
    check("a.u0.runDone_pulses", 32'(n_rd[0]), 32'd6);
    check("a.u1.dataOut_pulses", 32'(n_do[1]), 32'd1);
    check("a.u2.dataOut_pulses", 32'(n_do[2]), 32'd1);
    check("a.u2.runDone_pulses", 32'(n_rd[2]), 32'd6);

    // Saturation on the CNT_W=3, MIN_RUN=7 instance: twelve ones, then a zero.
    clear_counts();
    repeat (12) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("b.u3.runLen", 32'(o_rl[3]), 32'd7);
    check("b.u3.runSat", 32'(o_rs[3]), 32'd1);
    check("b.u3.dataOut_pulses", 32'(n_do[3]), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // Valid gaps do not break or extend a run.
    clear_counts();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("c.u0.runLen", 32'(o_rl[0]), 32'd3);
    check("c.u0.dataOut_pulses", 32'(n_do[0]), 32'd1);
    step(1'b0, 1'b0, 1'b1);

    // MIN_RUN=1: a pulse for every sample.
    clear_counts();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("d.u4.dataOut_pulses", 32'(n_do[4]), 32'd3);
    check("d.u4.runDone_pulses", 32'(n_rd[4]), 32'd2);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Reset mid-run discards the open run.
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    do_reset(2);
    clear_counts();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("e.u0.runVal", 32'(o_rv[0]), 32'd0);
    check("e.u0.runLen", 32'(o_rl[0]), 32'd1);
    check("e.u0.runDone_pulses", 32'(n_rd[0]), 32'd1);

    // Random stream: biased toward longer runs, with occasional gaps, flushes and resets.
    for (int n = 0; n < 600; n++) begin
      int r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 249) == 0) do_reset(1);
      if ($urandom_range(0, 5) == 0) cur = ~cur;
      step(r >= 25, cur, r < 4);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
